instr_fetch: RTL and testbench

//  Fetch unit acting as the read-side initiator of the synchronous instruction ROM (1-cycle read latency).

---
 rtl/instr_fetch.sv | 98 +++++++++
 tb/tb_instr_fetch.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit: sequential ROM reads, 2-entry return buffer, redirect/flush
// Read latency of the ROM is one cycle; issue credit keeps buffer + in-flight <= 2.
module instr_fetch #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  output logic              o_rd,
  output logic [ADDR_W-1:0] o_raddr,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_instr_valid,
  output logic [DATA_W-1:0] o_instr,
  output logic [ADDR_W-1:0] o_instr_pc,
  input  logic              i_instr_ready
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [ADDR_W-1:0] r_pc_q;
  logic              r_inflight;
  logic [DATA_W-1:0] r_buf_data [2];
  logic [ADDR_W-1:0] r_buf_pc   [2];
  logic              r_head;
  logic [1:0]        r_count;

  logic       w_pop, w_push, w_credit, w_wr_idx;
  logic [1:0] w_occ;

  assign o_instr_valid = (r_count != 2'd0);
  assign o_instr       = r_buf_data[r_head];
  assign o_instr_pc    = r_buf_pc[r_head];

  assign w_pop    = o_instr_valid & i_instr_ready;
  assign w_occ    = r_count + {1'b0, r_inflight};
  assign w_credit = (w_occ < 2'd2) || ((w_occ == 2'd2) && w_pop);
  // A return landing in a redirect cycle belongs to the abandoned path.
  assign w_push   = r_inflight & ~i_redirect;
  // With count==2 a push is only legal alongside a pop, which frees the head slot.
  assign w_wr_idx = r_head ^ r_count[0];

  always_comb begin
    w_state_nxt = i_en ? S_RUN : S_IDLE;
    o_rd        = 1'b0;
    o_raddr     = r_pc;
    w_pc_nxt    = r_pc;
    if (i_redirect) begin
      if (r_state == S_RUN) begin
        o_rd     = 1'b1;
        o_raddr  = i_redirect_pc;
        w_pc_nxt = i_redirect_pc + 1'b1;
      end else begin
        w_pc_nxt = i_redirect_pc;
      end
    end else if ((r_state == S_RUN) && w_credit) begin
      o_rd     = 1'b1;
      w_pc_nxt = r_pc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= ADDR_W'(RESET_PC);
      r_pc_q     <= '0;
      r_inflight <= 1'b0;
      r_head     <= 1'b0;
      r_count    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_buf_data[i] <= '0;
        r_buf_pc[i]   <= '0;
      end
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_inflight <= o_rd;
      if (o_rd) r_pc_q <= o_raddr;
      if (i_redirect) begin
        r_head  <= 1'b0;
        r_count <= 2'd0;
      end else begin
        if (w_push) begin
          r_buf_data[w_wr_idx] <= i_rdata;
          r_buf_pc[w_wr_idx]   <= r_pc_q;
        end
        r_head  <= r_head ^ w_pop;
        r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch: directed scenarios plus randomized traffic
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_en;
  logic        o_rd;
  logic [7:0]  o_raddr;
  logic [15:0] i_rdata;
  logic        i_redirect;
  logic [7:0]  i_redirect_pc;
  logic        o_instr_valid;
  logic [15:0] o_instr;
  logic [7:0]  o_instr_pc;
  logic        i_instr_ready;

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_W(8), .DATA_W(16), .RESET_PC(0)) dut (
    .clk(clk), .i_rst_n(rst_n), .i_en(i_en), .o_rd(o_rd), .o_raddr(o_raddr),
    .i_rdata(i_rdata), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_instr_valid(o_instr_valid), .o_instr(o_instr), .o_instr_pc(o_instr_pc),
    .i_instr_ready(i_instr_ready)
  );

  logic [15:0] rom [256];
  always @(posedge clk) i_rdata <= o_rd ? rom[o_raddr] : 16'($urandom);

  typedef struct packed { logic [7:0] pc; logic [15:0] data; } exp_t;
  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int pops  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Program order from a start PC: every accepted instruction must follow it.
  task automatic refill(input logic [7:0] start);
    exp_t e;
    logic [7:0] p;
    exp_q.delete();
    p = start;
    for (int i = 0; i < 1024; i++) begin
      e.pc = p;
      e.data = rom[p];
      exp_q.push_back(e);
      p = p + 8'd1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (i_redirect && rst_n) refill(i_redirect_pc);
    i_redirect = 1'b0;
  endtask

  logic        pv, pr, pdir;
  logic [15:0] pinstr;
  logic [7:0]  ppc;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      pv = 1'b0; pr = 1'b0; pdir = 1'b0;
    end else begin
      if (pv && !pr && !pdir) begin
        chk("hold_valid", 32'(o_instr_valid), 1);
        chk("hold_instr", 32'(o_instr), 32'(pinstr));
        chk("hold_pc", 32'(o_instr_pc), 32'(ppc));
      end
      if (o_instr_valid && i_instr_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_empty", 0, 1);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", 32'(o_instr_pc), 32'(e.pc));
          chk("sb_instr", 32'(o_instr), 32'(e.data));
          pops++;
        end
      end
      pv = o_instr_valid; pr = i_instr_ready; pdir = i_redirect;
      pinstr = o_instr; ppc = o_instr_pc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] h, t;
    logic       en_prev;
    for (int k = 0; k < 256; k++) rom[k] = 16'(k);
    refill(8'd0);
    rst_n = 1'b0; i_en = 1'b0; i_instr_ready = 1'b1;
    i_redirect = 1'b0; i_redirect_pc = 8'd0;
    #23;
    chk("rst_rd", 32'(o_rd), 0);
    chk("rst_raddr", 32'(o_raddr), 0);
    chk("rst_valid", 32'(o_instr_valid), 0);
    chk("rst_instr", 32'(o_instr), 0);
    chk("rst_pc", 32'(o_instr_pc), 0);

    // Basic streaming, latency and throughput
    tick(); rst_n = 1'b1;
    tick(); i_en = 1'b1; #1 chk("t1_idle_rd", 32'(o_rd), 0);
    tick(); #1 chk("t1_rd0", 32'(o_rd), 1); chk("t1_raddr0", 32'(o_raddr), 0); chk("t1_v0", 32'(o_instr_valid), 0);
    tick(); #1 chk("t1_rd1", 32'(o_rd), 1); chk("t1_raddr1", 32'(o_raddr), 1); chk("t1_v1", 32'(o_instr_valid), 0);
    tick(); #1 chk("t1_first_v", 32'(o_instr_valid), 1); chk("t1_first_pc", 32'(o_instr_pc), 0); chk("t1_first_i", 32'(o_instr), 0);
    for (int i = 1; i < 8; i++) begin
      tick(); #1;
      chk("t1_stream_v", 32'(o_instr_valid), 1);
      chk("t1_stream_pc", 32'(o_instr_pc), 32'(i));
      chk("t1_stream_i", 32'(o_instr), 32'(i));
    end

    // Backpressure
    tick(); i_instr_ready = 1'b0; #1;
    h = exp_q[0].pc;
    chk("t2_rd_stop", 32'(o_rd), 0);
    chk("t2_head", 32'(o_instr_pc), 32'(h));
    repeat (4) begin
      tick(); #1;
      chk("t2_rd_stop", 32'(o_rd), 0);
      chk("t2_held_pc", 32'(o_instr_pc), 32'(h));
    end
    tick(); i_instr_ready = 1'b1;
    repeat (6) begin
      #1 chk("t2_release_v", 32'(o_instr_valid), 1);
      tick();
    end

    // Redirect while streaming
    i_redirect = 1'b1; i_redirect_pc = 8'd5; #1;
    chk("t3_rd", 32'(o_rd), 1); chk("t3_raddr", 32'(o_raddr), 5);
    tick(); #1 chk("t3_bubble", 32'(o_instr_valid), 0);
    tick(); #1 chk("t3_v", 32'(o_instr_valid), 1); chk("t3_pc", 32'(o_instr_pc), 5); chk("t3_i", 32'(o_instr), 5);

    // Redirect across the address wrap
    tick(); i_redirect = 1'b1; i_redirect_pc = 8'd254; #1 chk("t4_raddr", 32'(o_raddr), 254);
    tick(); #1 chk("t4_bubble", 32'(o_instr_valid), 0);
    t = 8'd254;
    repeat (4) begin
      tick(); #1;
      chk("t4_v", 32'(o_instr_valid), 1);
      chk("t4_pc", 32'(o_instr_pc), 32'(t));
      chk("t4_i", 32'(o_instr), 32'(rom[t]));
      t = t + 8'd1;
    end

    // Asynchronous reset mid-stream
    tick(); #2 rst_n = 1'b0; #1;
    chk("t5_v", 32'(o_instr_valid), 0); chk("t5_rd", 32'(o_rd), 0);
    chk("t5_pc", 32'(o_instr_pc), 0); chk("t5_i", 32'(o_instr), 0);
    refill(8'd0);
    tick(); tick(); rst_n = 1'b1; #1 chk("t5_idle_rd", 32'(o_rd), 0);
    tick(); #1 chk("t5_rd", 32'(o_rd), 1); chk("t5_raddr", 32'(o_raddr), 0);
    tick(); tick(); #1 chk("t5_first_v", 32'(o_instr_valid), 1); chk("t5_first_pc", 32'(o_instr_pc), 0);
    repeat (3) tick();

    // Fetch disable with a read in flight
    i_en = 1'b0; i_instr_ready = 1'b0; #1;
    h = exp_q[0].pc;
    chk("t6_rd", 32'(o_rd), 0); chk("t6_head", 32'(o_instr_pc), 32'(h));
    repeat (4) begin
      tick(); #1;
      chk("t6_no_rd", 32'(o_rd), 0); chk("t6_v", 32'(o_instr_valid), 1); chk("t6_held", 32'(o_instr_pc), 32'(h));
    end
    tick(); i_en = 1'b1; i_instr_ready = 1'b1; #1 chk("t6_idle_rd", 32'(o_rd), 0);
    tick(); #1;
    t = exp_q[0].pc + 8'd1;
    chk("t6_resume_rd", 32'(o_rd), 1); chk("t6_resume_addr", 32'(o_raddr), 32'(t));
    repeat (4) tick();

    // Randomized traffic on random ROM contents
    rst_n = 1'b0; i_en = 1'b0;
    for (int k = 0; k < 256; k++) rom[k] = 16'($urandom);
    refill(8'd0);
    tick(); tick(); rst_n = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      tick();
      en_prev = i_en;
      i_en = ($urandom % 8) != 0;
      i_instr_ready = ($urandom % 3) != 0;
      if ($urandom % 25 == 0) begin
        i_redirect = 1'b1;
        i_redirect_pc = 8'($urandom);
      end
      #1;
      if (!en_prev) chk("rnd_idle_rd", 32'(o_rd), 0);
      else if (i_redirect) begin
        chk("rnd_redir_rd", 32'(o_rd), 1);
        chk("rnd_redir_addr", 32'(o_raddr), 32'(i_redirect_pc));
      end
    end
    tick(); i_en = 1'b1; i_instr_ready = 1'b1;
    repeat (5) tick();
    repeat (8) begin
      tick(); #1 chk("drain_v", 32'(o_instr_valid), 1);
    end
    chk("liveness", 32'(pops > 500), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
